// File: rtl/port_alloc_rr_pkg.sv
// port_alloc_rr_pkg: shared port-count defaults, index width helper and port mask type
package port_alloc_rr_pkg;
  localparam int NUM_PORT_DEF = 5;
  localparam int LOCAL_PORT_DEF = 4;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int PORT_IDX_W = idx_w(NUM_PORT_DEF);
  typedef logic [NUM_PORT_DEF-1:0] port_mask_t;
endpackage

// File: rtl/port_alloc_rr_rr_pick.sv
// port_alloc_rr_rr_pick: first set bit at or above ptr cyclically (mode=1) or highest set bit (mode=0)
module port_alloc_rr_rr_pick
  import port_alloc_rr_pkg::*;
#(
  parameter int N = NUM_PORT_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  // descending offset scan so the smallest offset from ptr is written last; ascending index scan leaves the highest
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (mode && mask[j]) idx = j;
    end
    for (int i = 0; i < N; i++) if (!mode && mask[i]) idx = IW'(i);
    any = |mask;
    for (int i = 0; i < N; i++) grant[i] = any && idx == IW'(i);
  end
endmodule

// File: rtl/port_alloc_rr.sv
// port_alloc_rr: registered single-flit port allocator with productive/deflection priority pickers
module port_alloc_rr
  import port_alloc_rr_pkg::*;
#(
  parameter int NUM_PORT = NUM_PORT_DEF,
  parameter int LOCAL_PORT = LOCAL_PORT_DEF,
  parameter int PRIO_MODE = 0,
  parameter int DEFLECT_LOCAL = 0,
  parameter int DEFL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [NUM_PORT-1:0]   req,
  input  logic [NUM_PORT-1:0]   avail,
  input  logic                  cnt_clr,
  output logic                  out_valid,
  output logic [NUM_PORT-1:0]   alloc,
  output logic [NUM_PORT-1:0]   remain,
  output logic                  deflected,
  output logic                  alloc_err,
  output logic [DEFL_CNT_W-1:0] defl_cnt
);
  localparam int IW = idx_w(NUM_PORT);
  localparam logic [IW-1:0] LAST = IW'(NUM_PORT - 1);
  logic [NUM_PORT-1:0] prod, cand, p_grant, d_grant, grant;
  logic [IW-1:0] prod_ptr, defl_ptr, p_idx, d_idx;
  logic p_any, d_any, need_defl, is_defl, is_err;
  port_alloc_rr_rr_pick #(.N(NUM_PORT)) u_prod (
    .mask(prod), .ptr(prod_ptr), .mode(PRIO_MODE != 0), .grant(p_grant), .idx(p_idx), .any(p_any)
  );
  port_alloc_rr_rr_pick #(.N(NUM_PORT)) u_defl (
    .mask(cand), .ptr(defl_ptr), .mode(PRIO_MODE != 0), .grant(d_grant), .idx(d_idx), .any(d_any)
  );
  // productive candidates only exist for a valid flit; the local port is a deflection target only when enabled
  always_comb begin
    prod = in_valid ? req & avail : '0;
    for (int i = 0; i < NUM_PORT; i++) cand[i] = avail[i] && (DEFLECT_LOCAL != 0 || i != LOCAL_PORT);
  end
  // productive grant wins; otherwise a requesting flit deflects or flags an error
  always_comb begin
    need_defl = in_valid && |req && !p_any;
    is_defl = need_defl && d_any;
    is_err = need_defl && !d_any;
    grant = p_any ? p_grant : is_defl ? d_grant : '0;
  end
  // output pipeline register, rotating pointers and saturating deflection counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      alloc <= '0;
      remain <= '0;
      deflected <= 1'b0;
      alloc_err <= 1'b0;
      prod_ptr <= '0;
      defl_ptr <= '0;
      defl_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      alloc <= grant;
      remain <= avail & ~grant;
      deflected <= is_defl;
      alloc_err <= is_err;
      if (PRIO_MODE != 0 && p_any) prod_ptr <= p_idx == LAST ? '0 : p_idx + 1'b1;
      if (PRIO_MODE != 0 && is_defl) defl_ptr <= d_idx == LAST ? '0 : d_idx + 1'b1;
      defl_cnt <= cnt_clr ? '0 : (is_defl && !(&defl_cnt)) ? defl_cnt + 1'b1 : defl_cnt;
    end
endmodule

// File: tb/tb_port_alloc_rr.sv
// tb_port_alloc_rr: directed vectors on four configurations with a queued scoreboard and decoupled monitor
module tb_port_alloc_rr;
  import port_alloc_rr_pkg::*;
  typedef struct {
    int id;
    port_mask_t al;
    port_mask_t rm;
    logic df;
    logic er;
    logic [15:0] cn;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, cnt_clr = 1'b0;
  logic [3:0] iv = '0;
  port_mask_t req = '0, avail = '0;
  logic ov[4], df[4], er[4];
  port_mask_t al[4], rm[4];
  logic [15:0] cn[4];
  logic [15:0] cn0, cn1, cn2;
  logic [1:0] cn3;
  int vecs = 0, errs = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  assign cn[0] = cn0;
  assign cn[1] = cn1;
  assign cn[2] = cn2;
  assign cn[3] = {14'b0, cn3};
  port_alloc_rr u0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .req(req), .avail(avail), .cnt_clr(cnt_clr),
    .out_valid(ov[0]), .alloc(al[0]), .remain(rm[0]), .deflected(df[0]), .alloc_err(er[0]), .defl_cnt(cn0)
  );
  port_alloc_rr #(.PRIO_MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .req(req), .avail(avail), .cnt_clr(cnt_clr),
    .out_valid(ov[1]), .alloc(al[1]), .remain(rm[1]), .deflected(df[1]), .alloc_err(er[1]), .defl_cnt(cn1)
  );
  port_alloc_rr #(.DEFLECT_LOCAL(1)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .req(req), .avail(avail), .cnt_clr(cnt_clr),
    .out_valid(ov[2]), .alloc(al[2]), .remain(rm[2]), .deflected(df[2]), .alloc_err(er[2]), .defl_cnt(cn2)
  );
  port_alloc_rr #(.DEFL_CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .req(req), .avail(avail), .cnt_clr(cnt_clr),
    .out_valid(ov[3]), .alloc(al[3]), .remain(rm[3]), .deflected(df[3]), .alloc_err(er[3]), .defl_cnt(cn3)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic apply(input int id, input port_mask_t rq, input port_mask_t av, input logic clr,
                       input port_mask_t ea, input port_mask_t erm, input logic ed, input logic ee,
                       input logic [15:0] ec);
    exp_t e;
    @(negedge clk);
    iv = '0;
    iv[id] = 1'b1;
    req = rq;
    avail = av;
    cnt_clr = clr;
    e.id = id;
    e.al = ea;
    e.rm = erm;
    e.df = ed;
    e.er = ee;
    e.cn = ec;
    q.push_back(e);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (ov[0] | ov[1] | ov[2] | ov[3]) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected out_valid with empty scoreboard");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("dut%0d {ov,alloc,remain,defl,err,cnt}", e.id),
            {35'b0, ov[e.id], al[e.id], rm[e.id], df[e.id], er[e.id], cn[e.id]},
            {35'b0, 1'b1, e.al, e.rm, e.df, e.er, e.cn});
      end
    end
  end
  initial begin
    #12;
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset dut%0d", k), {35'b0, ov[k], al[k], rm[k], df[k], er[k], cn[k]}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    apply(0, 5'b00110, 5'b11111, 1'b0, 5'b00100, 5'b11011, 1'b0, 1'b0, 16'd0);
    apply(0, 5'b00001, 5'b10110, 1'b0, 5'b00100, 5'b10010, 1'b1, 1'b0, 16'd1);
    apply(0, 5'b00000, 5'b11111, 1'b0, 5'b00000, 5'b11111, 1'b0, 1'b0, 16'd1);
    apply(0, 5'b00001, 5'b10000, 1'b0, 5'b00000, 5'b10000, 1'b0, 1'b1, 16'd1);
    apply(2, 5'b00001, 5'b10000, 1'b0, 5'b10000, 5'b00000, 1'b1, 1'b0, 16'd1);
    apply(1, 5'b00110, 5'b11111, 1'b0, 5'b00010, 5'b11101, 1'b0, 1'b0, 16'd0);
    apply(1, 5'b00110, 5'b11111, 1'b0, 5'b00100, 5'b11011, 1'b0, 1'b0, 16'd0);
    apply(1, 5'b00110, 5'b11111, 1'b0, 5'b00010, 5'b11101, 1'b0, 1'b0, 16'd0);
    apply(1, 5'b00001, 5'b01110, 1'b0, 5'b00010, 5'b01100, 1'b1, 1'b0, 16'd1);
    apply(1, 5'b00001, 5'b01110, 1'b0, 5'b00100, 5'b01010, 1'b1, 1'b0, 16'd2);
    apply(1, 5'b00001, 5'b01110, 1'b0, 5'b01000, 5'b00110, 1'b1, 1'b0, 16'd3);
    apply(1, 5'b00001, 5'b01110, 1'b0, 5'b00010, 5'b01100, 1'b1, 1'b0, 16'd4);
    apply(1, 5'b00110, 5'b11111, 1'b0, 5'b00100, 5'b11011, 1'b0, 1'b0, 16'd4);
    for (int n = 1; n <= 5; n++)
      apply(3, 5'b00001, 5'b10110, 1'b0, 5'b00100, 5'b10010, 1'b1, 1'b0, (n > 3) ? 16'd3 : 16'(n));
    apply(3, 5'b00001, 5'b10110, 1'b1, 5'b00100, 5'b10010, 1'b1, 1'b0, 16'd0);
    apply(3, 5'b00001, 5'b10110, 1'b0, 5'b00100, 5'b10010, 1'b1, 1'b0, 16'd1);
    @(negedge clk);
    iv = '0;
    cnt_clr = 1'b0;
    req = 5'b00001;
    avail = 5'b01010;
    @(posedge clk);
    #1;
    chk("idle pass-through dut0 {ov,alloc,remain,defl,err}",
        {51'b0, ov[0], al[0], rm[0], df[0], er[0]}, {51'b0, 1'b0, 5'b00000, 5'b01010, 1'b0, 1'b0});
    apply(1, 5'b00110, 5'b11111, 1'b0, 5'b00010, 5'b11101, 1'b0, 1'b0, 16'd0);
    @(posedge clk);
    #3;
    iv = '0;
    reset = 1'b1;
    #1;
    chk("async reset dut1", {35'b0, ov[1], al[1], rm[1], df[1], er[1], cn[1]}, 64'd0);
    chk("async reset dut3 cnt", {48'b0, cn[3]}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    apply(1, 5'b00110, 5'b11111, 1'b0, 5'b00010, 5'b11101, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    iv = '0;
    for (int t = 0; t < 20 && q.size() != 0; t++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL drain timeout: %0d outstanding, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
